imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the core's instruction-fetch port and data load/store port.
- The RAM has 1-cycle read latency and byte-lane write enables.
- Sits between the core top and the unified memory model/BRAM.
- Arbitrates per cycle: data access has priority, with a starvation guard that guarantees fetch forward progress. At most one read is outstanding.

---
 rtl/imem_dmem_arbiter.sv | 99 +++++++++
 tb/tb_imem_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data load/store.
// Data wins contention until the fetch-starvation streak limit forces a fetch grant.
module imem_dmem_arbiter #(
    parameter int ADDR_W          = 12,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak_q, streak_d;
    logic          if_pend_q, if_pend_d;
    logic          d_pend_q, d_pend_d;
    logic          force_if;

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        force_if  = if_req && (streak_q == STREAK_MAX);

        if (!rst) begin
            if (d_req && !force_if) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end

        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_be : 4'b0000;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_W+1:2];
        end

        // Streak only measures how long a waiting fetch has been passed over.
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end else begin
            streak_d = streak_q;
        end

        if_pend_d = if_gnt;
        d_pend_d  = d_gnt && !d_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q  <= '0;
            if_pend_q <= 1'b0;
            d_pend_q  <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            if_pend_q <= if_pend_d;
            d_pend_q  <= d_pend_d;
        end
    end

    // Gating with rst drops a response whose grant was immediately followed by reset.
    assign if_rvalid = if_pend_q && !rst;
    assign d_rvalid  = d_pend_q && !rst;
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_imem_dmem_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req, d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata;
    logic              d_gnt, d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    imem_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0; d_req = 0; d_we = 0; d_be = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 1; if_req = 1; d_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if_gnt !== 0 || d_gnt !== 0 || mem_en !== 0 || mem_we !== 0 || if_rvalid !== 0 || d_rvalid !== 0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: if_gnt=%b d_gnt=%b mem_en=%b mem_we=%b if_rv=%b d_rv=%b expected all 0",
                         i, if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid);
            end
            tick();
        end
        rst = 0;
        #1;
        checks++;
        if (d_gnt !== 1 || if_gnt !== 0) begin
            errors++;
            $display("FAIL reset_release: d_gnt=%b if_gnt=%b expected 1/0", d_gnt, if_gnt);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_fetch_only();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i < 3) begin if_req = 1; if_addr = 32'(4 * i); end
            #1;
            if (i < 3) begin
                checks++;
                if (if_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== ADDR_W'(i)) begin
                    errors++;
                    $display("FAIL fetch_grant %0d: if_gnt=%b mem_en=%b mem_we=%h mem_addr=%0d expected 1/1/0/%0d",
                             i, if_gnt, mem_en, mem_we, mem_addr, i);
                end
            end
            if (i > 0) begin
                checks++;
                if (if_rvalid !== 1 || if_rdata !== (32'hA000_0000 + 32'(i - 1)) || d_rvalid !== 0) begin
                    errors++;
                    $display("FAIL fetch_resp %0d: if_rvalid=%b if_rdata=%h d_rvalid=%b expected 1/%h/0",
                             i - 1, if_rvalid, if_rdata, d_rvalid, 32'hA000_0000 + 32'(i - 1));
                end
            end
            tick();
        end
    endtask

    task automatic test_store_load();
        idle();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hAABBCCDD;
        #1;
        checks++;
        if (d_gnt !== 1 || mem_we !== 4'b0011 || mem_addr !== 12'h040 || mem_wdata !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL store_drive: d_gnt=%b mem_we=%b mem_addr=%h mem_wdata=%h expected 1/0011/040/aabbccdd",
                     d_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        d_we = 0; d_be = 0; d_wdata = 0;
        #1;
        checks++;
        if (d_gnt !== 1 || mem_we !== 0 || mem_en !== 1 || d_rvalid !== 0) begin
            errors++;
            $display("FAIL load_drive: d_gnt=%b mem_we=%b mem_en=%b d_rvalid=%b expected 1/0/1/0", d_gnt, mem_we, mem_en, d_rvalid);
        end
        tick();
        idle();
        #1;
        checks++;
        if (d_rvalid !== 1 || d_rdata !== 32'h1122CCDD || if_rvalid !== 0) begin
            errors++;
            $display("FAIL load_resp: d_rvalid=%b d_rdata=%h if_rvalid=%b expected 1/1122ccdd/0", d_rvalid, d_rdata, if_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        logic prev_f;
        logic exp_f;
        prev_f = 0;
        for (int i = 0; i <= 10; i++) begin
            idle();
            if (i < 10) begin if_req = 1; if_addr = 32'h8; d_req = 1; d_addr = 32'h0; end
            exp_f = (i == 4) || (i == 9);
            #1;
            if (i < 10) begin
                checks++;
                if (if_gnt !== exp_f || d_gnt !== !exp_f) begin
                    errors++;
                    $display("FAIL contend_grant %0d: if_gnt=%b d_gnt=%b expected %b/%b", i, if_gnt, d_gnt, exp_f, !exp_f);
                end
            end
            if (i > 0) begin
                checks++;
                if (if_rvalid !== prev_f || d_rvalid !== !prev_f ||
                    if_rdata !== (prev_f ? 32'hA000_0002 : 32'h0) ||
                    d_rdata !== (prev_f ? 32'h0 : 32'hA000_0000)) begin
                    errors++;
                    $display("FAIL contend_resp %0d: if_rv=%b if_rd=%h d_rv=%b d_rd=%h expected if_rv=%b",
                             i, if_rvalid, if_rdata, d_rvalid, d_rdata, prev_f);
                end
            end
            prev_f = exp_f;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        idle();
        d_req = 1; d_addr = 32'h100;
        #1;
        checks++;
        if (d_gnt !== 1 || if_gnt !== 0) begin
            errors++;
            $display("FAIL b2b_load_grant: d_gnt=%b if_gnt=%b expected 1/0", d_gnt, if_gnt);
        end
        tick();
        idle();
        if_req = 1; if_addr = 32'h8;
        #1;
        checks++;
        if (if_gnt !== 1 || d_rvalid !== 1 || d_rdata !== 32'h1122CCDD || if_rvalid !== 0 || if_rdata !== 0) begin
            errors++;
            $display("FAIL b2b_n1: if_gnt=%b d_rv=%b d_rd=%h if_rv=%b if_rd=%h expected 1/1/1122ccdd/0/0",
                     if_gnt, d_rvalid, d_rdata, if_rvalid, if_rdata);
        end
        tick();
        idle();
        #1;
        checks++;
        if (if_rvalid !== 1 || if_rdata !== 32'hA000_0002 || d_rvalid !== 0 || d_rdata !== 0) begin
            errors++;
            $display("FAIL b2b_n2: if_rv=%b if_rd=%h d_rv=%b d_rd=%h expected 1/a0000002/0/0",
                     if_rvalid, if_rdata, d_rvalid, d_rdata);
        end
        tick();
    endtask

    task automatic test_empty_store_wrap();
        idle();
        d_req = 1; d_we = 1; d_be = 4'b0000; d_addr = 32'h4000_0004; d_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (d_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 12'h001 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL empty_store: d_gnt=%b mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h expected 1/1/0/001/deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        d_we = 0; d_addr = 32'h0000_0007; d_wdata = 0;
        #1;
        checks++;
        if (d_rvalid !== 0 || mem_addr !== 12'h001) begin
            errors++;
            $display("FAIL empty_store_norv: d_rvalid=%b mem_addr=%h expected 0/001", d_rvalid, mem_addr);
        end
        tick();
        idle();
        #1;
        checks++;
        if (d_rvalid !== 1 || d_rdata !== 32'hA000_0001) begin
            errors++;
            $display("FAIL empty_store_ram: d_rvalid=%b d_rdata=%h expected 1/a0000001", d_rvalid, d_rdata);
        end
        tick();
    endtask

    task automatic test_streak_reset();
        idle();
        if_req = 1; d_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (d_gnt !== 1) begin
                errors++;
                $display("FAIL streak_build %0d: d_gnt=%b expected 1", i, d_gnt);
            end
            tick();
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (d_gnt !== 1 || if_gnt !== 0) begin
            errors++;
            $display("FAIL streak_cleared: d_gnt=%b if_gnt=%b expected 1/0", d_gnt, if_gnt);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        idle();
        if_req = 1; if_addr = 32'h4;
        #1;
        checks++;
        if (if_gnt !== 1) begin
            errors++;
            $display("FAIL midrd_grant: if_gnt=%b expected 1", if_gnt);
        end
        tick();
        idle();
        rst = 1;
        #1;
        checks++;
        if (if_rvalid !== 0 || if_rdata !== 0) begin
            errors++;
            $display("FAIL midrd_n1: if_rvalid=%b if_rdata=%h expected 0/0", if_rvalid, if_rdata);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (if_rvalid !== 0 || d_rvalid !== 0) begin
            errors++;
            $display("FAIL midrd_n2: if_rvalid=%b d_rvalid=%b expected 0/0", if_rvalid, d_rvalid);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;
        ram[0] = 32'hA000_0000;
        ram[1] = 32'hA000_0001;
        ram[2] = 32'hA000_0002;
        ram[12'h040] = 32'h11223344;
        idle();
        rst = 1;
        tick();
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_empty_store_wrap();
        test_streak_reset();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
